// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Every output is a register or a decode of registered count, so there is
// no combinational path from winc/rinc/wdata to any output.
module sync_fifo_param #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 2**ASIZE - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic             wr_ok, rd_ok;

  // Accept decisions use the flags as they stand before the edge; a full
  // FIFO still accepts a read, an empty one still accepts a write.
  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  // Flags decoded from the registered occupancy.
  assign wfull         = (count == DEPTH_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);

  // Storage array; deliberately not reset, stale words are unreachable
  // because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  // Pointers, occupancy, read data register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ONE;
      if (rd_ok) begin
        rptr  <= rptr + ONE;
        rdata <= mem[rptr[ASIZE-1:0]];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (DSIZE=8, ASIZE=4). The driver applies
// directed vectors and pushes the expected post-edge state of a queue-based
// reference model into a scoreboard; a monitor pops one entry per cycle on
// the falling edge and compares it against the DUT outputs.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] rd;
    int         cnt;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_ov = 1'b0, m_un = 1'b0;

  sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the reference model advances from its pre-edge
  // state and the expected result goes to the scoreboard.
  task automatic step(input bit r_st, input bit w, input logic [7:0] wd, input bit r);
    exp_t e;
    bit   full, empty;
    rst = r_st; winc = w; wdata = wd; rinc = r;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (r_st) begin
      mq.delete();
      m_rdata = 8'h00; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      if (w && full)  m_ov = 1'b1;
      if (r && empty) m_un = 1'b1;
      if (r && !empty) m_rdata = mq.pop_front();
      if (w && !full)  mq.push_back(wd);
    end
    e.rd = m_rdata; e.cnt = mq.size(); e.ov = m_ov; e.un = m_un;
    exp_q.push_back(e);
    #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
  endtask

  // Monitor: compare DUT state with the scoreboard entry for the last edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rdata",         int'(rdata),         int'(e.rd));
      chk("count",         int'(count),         e.cnt);
      chk("wfull",         int'(wfull),         int'(e.cnt == DEPTH));
      chk("rempty",        int'(rempty),        int'(e.cnt == 0));
      chk("walmost_full",  int'(walmost_full),  int'(e.cnt >= AF));
      chk("ralmost_empty", int'(ralmost_empty), int'(e.cnt <= AE));
      chk("overflow",      int'(overflow),      int'(e.ov));
      chk("underflow",     int'(underflow),     int'(e.un));
    end
  end

  initial begin
    // Reset for two cycles.
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_ralmost_empty", int'(ralmost_empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_rdata", int'(rdata), 0);

    // Fill with 0x00..0x0F, checking threshold crossings directly.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0);
      if (i == 0)  chk("first_wr_rempty", int'(rempty), 0);
      if (i == 1)  chk("cnt2_ralmost_empty", int'(ralmost_empty), 1);
      if (i == 2)  chk("cnt3_ralmost_empty", int'(ralmost_empty), 0);
      if (i == 12) chk("cnt13_walmost_full", int'(walmost_full), 0);
      if (i == 13) chk("cnt14_walmost_full", int'(walmost_full), 1);
      if (i == 14) chk("cnt15_wfull", int'(wfull), 0);
    end
    chk("fill_wfull", int'(wfull), 1);
    chk("fill_count", int'(count), 16);

    // Overflow: write while full is rejected.
    step(0, 1, 8'hAA, 0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);

    // Drain: data must come out 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      chk("drain_data", int'(rdata), i);
    end
    chk("drain_rempty", int'(rempty), 1);

    // 40 more words streamed with simultaneous write/read across the wrap.
    step(0, 1, 8'h20, 0);
    for (int i = 1; i < 40; i++) step(0, 1, 8'(8'h20 + i), 1);
    step(0, 0, 8'h00, 1);
    chk("stream_last", int'(rdata), 8'h47);
    chk("stream_rempty", int'(rempty), 1);

    // Underflow with simultaneous access on empty.
    step(0, 1, 8'h55, 1);
    chk("unf_count", int'(count), 1);
    chk("unf_flag", int'(underflow), 1);
    chk("unf_rdata_hold", int'(rdata), 8'h47);
    step(0, 0, 8'h00, 1);
    chk("unf_next_read", int'(rdata), 8'h55);

    // Simultaneous access on full.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'h77, 1);
    chk("full_rw_rdata", int'(rdata), 8'h00);
    chk("full_rw_count", int'(count), 15);
    chk("full_rw_ovf", int'(overflow), 1);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      chk("full_rw_drain", int'(rdata), i);
    end
    chk("full_rw_empty", int'(rempty), 1);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'hC0 + i), 0);
    chk("pre_rst_count", int'(count), 9);
    step(1, 1, 8'hEE, 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_rempty", int'(rempty), 1);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_unf", int'(underflow), 0);
    step(0, 1, 8'h99, 0);
    step(0, 0, 8'h00, 1);
    chk("post_rst_data", int'(rdata), 8'h99);

    // Let the monitor consume the final entry, then confirm nothing is left.
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
